// File: rtl/k16_mem_pkg.sv
// Shared memory-side types and default widths for the K16 core.
// Used by the SM arbiter and any other memory-port logic.
package k16_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_HOST
  } owner_t;

  localparam int unsigned SmDataWidth = 16;
  localparam int unsigned SmAddrWidth = 8;
  localparam int unsigned PmDataWidth = 24;
  localparam int unsigned PmAddrWidth = 8;

endpackage

// File: rtl/sm_fair_cnt.sv
// Saturating starvation counter: counts consecutive contested CPU wins.
// sat tells the arbiter the host must be forced in.
module sm_fair_cnt #(
  parameter int unsigned MaxHold = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clear,
  output logic sat
);

  logic [3:0] cnt_q, cnt_d;

  assign sat = (cnt_q == 4'(MaxHold));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sm_arbiter.sv
// Two-port arbiter for the K16 stack/data memory: CPU has fixed priority,
// bounded by a starvation guard; read data is routed back to its owner.
module sm_arbiter
  import k16_mem_pkg::*;
#(
  parameter int unsigned DataWidth = SmDataWidth,
  parameter int unsigned AddrWidth = SmAddrWidth,
  parameter int unsigned MaxHold   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [15:0]          cpu_addr,
  input  logic [DataWidth-1:0] cpu_wdata,
  output logic                 cpu_stall,
  output logic [DataWidth-1:0] cpu_rdata,
  output logic                 cpu_rvalid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [15:0]          host_addr,
  input  logic [DataWidth-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [DataWidth-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [DataWidth-1:0] mem_rdata
);

  owner_t rd_owner_q, rd_owner_d;
  logic   cpu_gnt;
  logic   sat;

  sm_fair_cnt #(
    .MaxHold(MaxHold)
  ) u_fair_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cpu_req & host_req & cpu_gnt),
    .clear(host_gnt | ~host_req),
    .sat  (sat)
  );

  always_comb begin
    host_gnt = !rst && host_req && (!cpu_req || sat);
    cpu_gnt  = !rst && cpu_req && !host_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;

    // With no winner the CPU address is presented as a harmless read.
    mem_addr  = cpu_addr[AddrWidth-1:0];
    mem_wdata = cpu_wdata;
    mem_we    = cpu_gnt & cpu_we;
    if (host_gnt) begin
      mem_addr  = host_addr[AddrWidth-1:0];
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end

    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (host_gnt && !host_we) begin
      rd_owner_d = OWN_HOST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // A read in flight when reset rises is dropped rather than returned.
  assign cpu_rvalid  = !rst && (rd_owner_q == OWN_CPU);
  assign host_rvalid = !rst && (rd_owner_q == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_sm_arbiter.sv
// Directed bench for sm_arbiter: behavioural model with per-cycle compare
// plus hand-computed expectations from the test plan.
module tb_sm_arbiter;

  localparam int unsigned Dw = 16;
  localparam int unsigned Aw = 8;
  localparam int MaxHold = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [15:0]   cpu_addr;
  logic [Dw-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall, cpu_rvalid;
  logic          host_req, host_we;
  logic [15:0]   host_addr;
  logic [Dw-1:0] host_wdata, host_rdata;
  logic          host_gnt, host_rvalid;
  logic [Aw-1:0] mem_addr;
  logic [Dw-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  int n_vec = 0;
  int n_err = 0;

  sm_arbiter #(
    .DataWidth(Dw),
    .AddrWidth(Aw),
    .MaxHold  (MaxHold)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the arbiter.
  logic [Dw-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Model: its own memory image, contested-cycle run length, pending read.
  logic [Dw-1:0] m_mem [256];
  int            m_run   = 0;
  int            m_pend  = 0;  // 0 none, 1 cpu, 2 host
  logic [Dw-1:0] m_pdata = '0;

  // 0 nobody, 1 cpu, 2 host
  function automatic int winner();
    if (rst) return 0;
    if (cpu_req && !host_req) return 1;
    if (host_req && !cpu_req) return 2;
    if (cpu_req && host_req) return (m_run == MaxHold) ? 2 : 1;
    return 0;
  endfunction

  task automatic check(input string name, input logic [Dw-1:0] act, input logic [Dw-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int w;
    w = winner();
    if (rst) begin
      m_run  <= 0;
      m_pend <= 0;
    end else begin
      if (w == 2 || !host_req) m_run <= 0;
      else if (cpu_req && host_req && m_run < MaxHold) m_run <= m_run + 1;
      m_pend <= 0;
      if (w == 1) begin
        if (cpu_we) m_mem[cpu_addr[7:0]] <= cpu_wdata;
        else begin
          m_pend  <= 1;
          m_pdata <= m_mem[cpu_addr[7:0]];
        end
      end else if (w == 2) begin
        if (host_we) m_mem[host_addr[7:0]] <= host_wdata;
        else begin
          m_pend  <= 2;
          m_pdata <= m_mem[host_addr[7:0]];
        end
      end
    end
  end

  always @(negedge clk) begin
    int w;
    logic exp_we;
    w = winner();
    exp_we = (w == 1) ? cpu_we : (w == 2) ? host_we : 1'b0;
    check("cpu_stall", Dw'(cpu_stall), Dw'(cpu_req && w != 1));
    check("host_gnt", Dw'(host_gnt), Dw'(w == 2));
    check("mem_we", Dw'(mem_we), Dw'(exp_we));
    check("mem_addr", Dw'(mem_addr), Dw'((w == 2) ? host_addr[7:0] : cpu_addr[7:0]));
    if (exp_we) check("mem_wdata", mem_wdata, (w == 2) ? host_wdata : cpu_wdata);
    check("cpu_rvalid", Dw'(cpu_rvalid), Dw'(m_pend == 1 && !rst));
    check("host_rvalid", Dw'(host_rvalid), Dw'(m_pend == 2 && !rst));
    check("cpu_rdata", cpu_rdata, (m_pend == 1 && !rst) ? m_pdata : '0);
    check("host_rdata", host_rdata, (m_pend == 2 && !rst) ? m_pdata : '0);
  end

  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [Dw-1:0] cd, input logic hr, input logic hw,
                       input logic [15:0] ha, input logic [Dw-1:0] hd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b0, 16'h0000, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]   = Dw'(i * 257);
      m_mem[i] = Dw'(i * 257);
    end
    ram[8'h12]   = 16'hBEEF;
    m_mem[8'h12] = 16'hBEEF;
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0012, '0, 1'b0, 1'b0, 16'h0000, '0);

    // Reset state
    @(negedge clk);
    check("rst_cpu_stall", Dw'(cpu_stall), 16'd1);
    check("rst_host_gnt", Dw'(host_gnt), 16'd0);
    check("rst_mem_we", Dw'(mem_we), 16'd0);
    check("rst_cpu_rvalid", Dw'(cpu_rvalid), 16'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // CPU-only read
    drive(1'b1, 1'b0, 16'h0012, '0, 1'b0, 1'b0, 16'h0000, '0);
    @(negedge clk);
    check("t1_stall", Dw'(cpu_stall), 16'd0);
    check("t1_addr", Dw'(mem_addr), 16'h0012);
    tick();
    idle();
    @(negedge clk);
    check("t1_rvalid", Dw'(cpu_rvalid), 16'd1);
    check("t1_rdata", cpu_rdata, 16'hBEEF);
    check("t1_host_rvalid", Dw'(host_rvalid), 16'd0);
    tick();

    // Host-only write then read back
    drive(1'b0, 1'b0, 16'h0000, '0, 1'b1, 1'b1, 16'h00FF, 16'h1234);
    @(negedge clk);
    check("t2_wr_gnt", Dw'(host_gnt), 16'd1);
    check("t2_wr_we", Dw'(mem_we), 16'd1);
    tick();
    drive(1'b0, 1'b0, 16'h0000, '0, 1'b1, 1'b0, 16'h00FF, '0);
    @(negedge clk);
    check("t2_rd_gnt", Dw'(host_gnt), 16'd1);
    tick();
    idle();
    @(negedge clk);
    check("t2_rvalid", Dw'(host_rvalid), 16'd1);
    check("t2_rdata", host_rdata, 16'h1234);
    tick();

    // Continuous contention: host forced in on cycle MaxHold+1
    drive(1'b1, 1'b0, 16'h0020, '0, 1'b1, 1'b0, 16'h0030, '0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("t3_host_gnt", Dw'(host_gnt), Dw'(c == 5));
      check("t3_cpu_stall", Dw'(cpu_stall), Dw'(c == 5));
      tick();
    end
    idle();
    tick();

    // CPU write, host read next cycle through an aliased address
    drive(1'b1, 1'b1, 16'h0040, 16'hAAAA, 1'b0, 1'b0, 16'h0000, '0);
    @(negedge clk);
    check("t4_we", Dw'(mem_we), 16'd1);
    check("t4_wdata", mem_wdata, 16'hAAAA);
    tick();
    drive(1'b0, 1'b0, 16'h0000, '0, 1'b1, 1'b0, 16'h0140, '0);
    @(negedge clk);
    check("t4_alias_addr", Dw'(mem_addr), 16'h0040);
    tick();
    idle();
    @(negedge clk);
    check("t4_rvalid", Dw'(host_rvalid), 16'd1);
    check("t4_rdata", host_rdata, 16'hAAAA);
    tick();

    // Reset with a read in flight
    drive(1'b1, 1'b0, 16'h0012, '0, 1'b0, 1'b0, 16'h0000, '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rvalid_rst", Dw'(cpu_rvalid), 16'd0);
    check("t5_stall_rst", Dw'(cpu_stall), 16'd1);
    check("t5_we_rst", Dw'(mem_we), 16'd0);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("t5_rvalid_after", Dw'(cpu_rvalid), 16'd0);
    tick();
    drive(1'b1, 1'b0, 16'h0021, '0, 1'b1, 1'b0, 16'h0031, '0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("t5_restart_gnt", Dw'(host_gnt), Dw'(c == 5));
      tick();
    end
    idle();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sm_arbiter.md
# sm_arbiter

Two-port arbiter for the single-port synchronous stack/data memory (SM, 16-bit × 256) in the K16 core. It multiplexes the Processor's data port and a host/debug port (loader, monitor) onto the RAM's one address/write port, stalls the loser, and routes one-cycle-latency read data back to the owner of each access. The Processor has fixed priority, bounded by a starvation guard that gives the host a slot after `MaxHold` consecutive contested cycles.

## Interface
- `DataWidth`, 16: word width of SM and both requesters.
- `AddrWidth`, 8: RAM address width; requester addresses are 16 bits and truncated to `[AddrWidth-1:0]`.
- `MaxHold`, 4: consecutive contested CPU grants before the host is forced in (1..15).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: Processor access request, held until granted.
- `cpu_we` in 1: write enable, 1 = write, 0 = read.
- `cpu_addr` in 16: word address.
- `cpu_wdata` in DataWidth: write data.
- `cpu_stall` out 1: `cpu_req` not granted this cycle.
- `cpu_rdata` out DataWidth: read data, valid while `cpu_rvalid` is high.
- `cpu_rvalid` out 1: one-cycle pulse, read data for the CPU.
- `host_req`, `host_we`, `host_addr`[16], `host_wdata`[DataWidth] in: same meaning as the CPU-side signals.
- `host_gnt` out 1: host request accepted this cycle.
- `host_rdata` out DataWidth, `host_rvalid` out 1: same meaning as the CPU-side signals.
- `mem_addr` out AddrWidth, `mem_wdata` out DataWidth, `mem_we` out 1: RAM port.
- `mem_rdata` in DataWidth: RAM synchronous read output (address registered at the edge, data the next cycle).

## Operation
- Grant is combinational from the current requests plus registered state:
  - Only one requester active: that requester wins.
  - Both active: the CPU wins unless `starve_cnt == MaxHold`, in which case the host wins.
- `starve_cnt` (4 bits) behaviour:
  - Increments on each cycle where both request and the CPU wins.
  - Clears when the host is granted or `host_req` is low.
  - Saturates at `MaxHold`.
- `cpu_stall = cpu_req & ~cpu_gnt`. `host_gnt` is high only when the host wins.
- RAM port is driven by the winner's addr/wdata/we.
  - No winner: `mem_we = 0` and `mem_addr` holds the CPU's address (harmless read).
- Response tracking:
  - Registered `rd_owner` ∈ {NONE, CPU, HOST} = winner of a read in this cycle, NONE for writes and idle cycles.
  - Next cycle: `cpu_rvalid = (rd_owner == CPU)`, `host_rvalid = (rd_owner == HOST)`.
  - `cpu_rdata`/`host_rdata` = `mem_rdata` when the matching rvalid is high, else 0.
- Address truncation: bits above `AddrWidth` are ignored (0x0105 accesses word 0x05). No error flag.
- Simultaneous write and read to the same address by different requesters: serialized by grant order. A read granted the cycle after a write returns the new data.
- Back-to-back grants are allowed every cycle. A new read may be granted in the cycle its predecessor's data returns.
- While `rst` is high:
  - Both grants forced low, so `cpu_stall = cpu_req`.
  - `mem_we = 0`.
- Reset state: `starve_cnt = 0`, `rd_owner = NONE`.
- Reset mid-operation: any read in flight is dropped, and no rvalid pulses in the cycle after reset.

## Timing
- Reset values of all outputs: `cpu_stall = cpu_req`, `host_gnt = 0`, both rvalids 0, both rdatas 0, `mem_we = 0`.
- Request to grant: 0 cycles (same cycle, combinational).
- Write: committed at the edge ending the grant cycle.
- Read: data and rvalid appear exactly 1 cycle after the grant cycle, high for 1 cycle.
- Worst-case host wait under continuous CPU traffic: `MaxHold` cycles, granted in cycle `MaxHold+1`.
- Requirement on requesters: hold req/we/addr/wdata stable until granted. The arbiter does not latch them.

## Structure
- Shared package `k16_mem_pkg`:
  - `owner_t` enum {OWN_NONE, OWN_CPU, OWN_HOST}.
  - Default SM widths (16/8) and PM widths (24/8).
- One natural sub-module: `sm_fair_cnt`, the saturating starvation counter with inc/clear/sat outputs.
- The grant mux and response routing stay in `sm_arbiter`.

## Test plan
- CPU-only read of 0x0012 holding 0xBEEF: `cpu_stall = 0`, `mem_addr = 0x12`, next cycle `cpu_rvalid = 1`, `cpu_rdata = 0xBEEF`, `host_rvalid = 0`.
- Host-only write of 0x1234 to 0x00FF, then host read of 0x00FF: `host_gnt` high both cycles, read returns 0x1234 one cycle later.
- Both request continuously, MaxHold = 4: CPU granted cycles 1–4 with `host_gnt = 0`, host granted in cycle 5 with `cpu_stall = 1`, CPU granted again in cycle 6.
- CPU write 0xAAAA to 0x0040 granted, host read of 0x0040 granted next cycle: host reads 0xAAAA. Address 0x0140 aliases to 0x40.
- Read granted, then `rst` asserted the next cycle: no rvalid in the cycle after reset, `mem_we = 0`, `cpu_stall` follows `cpu_req` during reset, counter restarts at 0.
